// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM arbiter (state encoding, grant owner, reset level).
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package sram_arbiter_pkg;

    // Reset is asserted when rst carries this level.
    localparam logic RST_ENABLE = 1'b0;

    // Width of the ACCESS-phase wait counter; bounds WAIT_CYCLES to 0..7.
    localparam int WAIT_CNT_W = 3;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_IF  = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

endpackage

// File: rtl/sram_arbiter.sv
// Shares one async SRAM between fetch and MEM; MEM wins ties. Optional fetch-stall counter: SRAM_ARB_STAT_EN.
// Latency: ready pulses WAIT_CYCLES+2 cycles after the IDLE cycle that sampled the request.
// Backpressure: the unserved or in-flight requester is held by stall_req until its ready pulse.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              stall_req,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_wdata_oe,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [15:0]       stat_if_stall
);

    // Index of the final ACCESS cycle; ACCESS therefore spans WAIT_CYCLES+1 cycles.
    localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(WAIT_CYCLES);

    arb_state_t              state;
    grant_t                  grant;
    logic                    is_write;
    logic [WAIT_CNT_W-1:0]   wait_cnt;

    // Arbitration FSM; every SRAM pin and requester output is registered here.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state         <= ARB_IDLE;
            grant         <= GRANT_IF;
            is_write      <= 1'b0;
            wait_cnt      <= '0;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
            sram_wdata_oe <= 1'b0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            if_ready      <= 1'b0;
            mem_ready     <= 1'b0;
            if_rdata      <= '0;
            mem_rdata     <= '0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    wait_cnt <= '0;
                    if (mem_req) begin
                        state         <= ARB_ACCESS;
                        grant         <= GRANT_MEM;
                        is_write      <= mem_we;
                        sram_addr     <= mem_addr;
                        sram_wdata    <= mem_wdata;
                        sram_ce_n     <= 1'b0;
                        sram_oe_n     <= mem_we;
                        sram_we_n     <= ~mem_we;
                        sram_wdata_oe <= mem_we;
                    end else if (if_req) begin
                        state         <= ARB_ACCESS;
                        grant         <= GRANT_IF;
                        is_write      <= 1'b0;
                        sram_addr     <= if_addr;
                        sram_ce_n     <= 1'b0;
                        sram_oe_n     <= 1'b0;
                        sram_we_n     <= 1'b1;
                        sram_wdata_oe <= 1'b0;
                    end
                end
                ARB_ACCESS: begin
                    if (wait_cnt == LAST_CNT) begin
                        // Strobes rise while address/data stay put; the data bus
                        // keeps driving through DONE to cover write hold time.
                        state     <= ARB_DONE;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        if (grant == GRANT_MEM) begin
                            mem_ready <= 1'b1;
                            if (!is_write) begin
                                mem_rdata <= sram_rdata;
                            end
                        end else begin
                            if_ready <= 1'b1;
                            if_rdata <= sram_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                    end
                end
                ARB_DONE: begin
                    state         <= ARB_IDLE;
                    sram_wdata_oe <= 1'b0;
                end
                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // A requester stalls the pipeline until the cycle its ready pulse appears.
    assign stall_req = (if_req & ~if_ready) | (mem_req & ~mem_ready);

`ifdef SRAM_ARB_STAT_EN
    logic [15:0] stall_cnt;

    // Saturating count of cycles in which fetch is waiting.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            stall_cnt <= 16'h0000;
        end else if (if_req && !if_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'h0001;
        end
    end

    assign stat_if_stall = stall_cnt;
`else
    assign stat_if_stall = 16'h0000;
`endif

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed table, reset corner cases, random traffic against a transaction-level model.
// Latency: n/a (testbench).
// Backpressure: requesters hold req/addr/data until their ready pulse.
`timescale 1ns/1ps
module tb_sram_arbiter;

    localparam int W  = 1;
    localparam int AW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst;

    // Main DUT (WAIT_CYCLES = 1)
    logic          if_req, if_ready, mem_req, mem_we, mem_ready, stall_req;
    logic [AW-1:0] if_addr, mem_addr, sram_addr;
    logic [DW-1:0] if_rdata, mem_wdata, mem_rdata, sram_wdata, sram_rdata;
    logic          sram_wdata_oe, sram_ce_n, sram_oe_n, sram_we_n;
    logic [15:0]   stat_if_stall;

    // Fast DUT (WAIT_CYCLES = 0), fetch only
    logic          if_req_b, if_ready_b, mem_ready_b, stall_req_b;
    logic [AW-1:0] if_addr_b, sram_addr_b;
    logic [DW-1:0] if_rdata_b, mem_rdata_b, sram_wdata_b, sram_rdata_b;
    logic          sram_wdata_oe_b, sram_ce_n_b, sram_oe_n_b, sram_we_n_b;
    logic [15:0]   stat_if_stall_b;
    logic          zero_b = 1'b0;
    logic [AW-1:0] zero_a = '0;
    logic [DW-1:0] zero_d = '0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .stall_req(stall_req),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_wdata_oe(sram_wdata_oe),
        .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .stat_if_stall(stat_if_stall)
    );

    sram_arbiter #(.WAIT_CYCLES(0), .ADDR_W(AW), .DATA_W(DW)) dut_fast (
        .clk(clk), .rst(rst),
        .if_req(if_req_b), .if_addr(if_addr_b), .if_rdata(if_rdata_b), .if_ready(if_ready_b),
        .mem_req(zero_b), .mem_we(zero_b), .mem_addr(zero_a), .mem_wdata(zero_d),
        .mem_rdata(mem_rdata_b), .mem_ready(mem_ready_b), .stall_req(stall_req_b),
        .sram_addr(sram_addr_b), .sram_wdata(sram_wdata_b), .sram_wdata_oe(sram_wdata_oe_b),
        .sram_rdata(sram_rdata_b), .sram_ce_n(sram_ce_n_b), .sram_oe_n(sram_oe_n_b),
        .sram_we_n(sram_we_n_b), .stat_if_stall(stat_if_stall_b)
    );

    // Power-up content of the SRAM: every word starts as 6A01 ^ low address byte.
    function automatic logic [15:0] init_word(input logic [15:0] a);
        return 16'h6A01 ^ {8'h00, a[7:0]};
    endfunction

    // SRAM device model (256 words, aliased on the low address byte).
    logic [15:0] sram_mem [0:255];
    bit          written  [0:255];
    assign sram_rdata = (!sram_ce_n && !sram_oe_n) ?
                        (written[sram_addr[7:0]] ? sram_mem[sram_addr[7:0]] : init_word(sram_addr)) :
                        16'hDEAD;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_wdata_oe) begin
            sram_mem[sram_addr[7:0]] <= sram_wdata;
            written[sram_addr[7:0]]  <= 1'b1;
        end
    end
    assign sram_rdata_b = (!sram_ce_n_b && !sram_oe_n_b) ? init_word(sram_addr_b) : 16'hDEAD;

    // Reference memory for the random phase, updated at transaction level.
    logic [15:0] ref_mem [0:255];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Drives one request set from an IDLE cycle and measures it. Cycle 1 is the IDLE
    // cycle that samples the request; ready cycles are reported on that scale.
    task automatic run_txn(input logic ir, input logic mr, input logic we,
                           input logic [15:0] ia, input logic [15:0] ma, input logic [15:0] wd,
                           input int exp_ic, input int exp_mc, input string tag,
                           output int ic, output int mc, output logic [15:0] id, output logic [15:0] md,
                           output int ce, output int oe, output int wen, output int drv);
        int  cyc;
        bit  if_pend, mem_pend;
        ic = 0; mc = 0; id = '0; md = '0; ce = 0; oe = 0; wen = 0; drv = 0;
        if_req = ir; mem_req = mr; mem_we = we; if_addr = ia; mem_addr = ma; mem_wdata = wd;
        if_pend = ir; mem_pend = mr;
        cyc = 1;
        while ((if_pend || mem_pend) && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (!sram_ce_n) ce++;
            if (!sram_oe_n) oe++;
            if (!sram_we_n) wen++;
            if (sram_wdata_oe) drv++;
            chk({tag, "_stall"}, {31'b0, stall_req},
                {31'b0, (if_pend && cyc != exp_ic) || (mem_pend && cyc != exp_mc)});
            if (mem_ready) begin
                if (mc == 0) begin mc = cyc; md = mem_rdata; end
                mem_pend = 1'b0; mem_req = 1'b0;
            end
            if (if_ready) begin
                if (ic == 0) begin ic = cyc; id = if_rdata; end
                if_pend = 1'b0; if_req = 1'b0;
            end
        end
        if (if_pend || mem_pend) begin
            chk({tag, "_timeout"}, 32'd1, 32'd0);
            if_req = 1'b0; mem_req = 1'b0;
        end
        // Trailing IDLE cycle: nothing may still be driven.
        @(negedge clk);
        if (!sram_ce_n) ce++;
        if (!sram_oe_n) oe++;
        if (!sram_we_n) wen++;
        if (sram_wdata_oe) drv++;
    endtask

    typedef struct {
        logic        ir, mr, we;
        logic [15:0] ia, ma, wd;
        int          exp_ic, exp_mc;
        logic [15:0] exp_id, exp_md;
        int          exp_ce, exp_oe, exp_we, exp_drv;
    } vec_t;

    initial begin
        vec_t        vecs [6];
        int          ic, mc, ce, oe, wen, drv, cyc, nrdy, fast_bad;
        int          e_ic, e_mc;
        logic [15:0] id, md, e_id, e_md;
        logic        ir, mr, we;
        logic [15:0] ia, ma, wd;
        logic [15:0] fast_addr [3];
        int          fast_cyc  [3];

        rst = 1'b0;
        if_req = 0; mem_req = 0; mem_we = 0; if_addr = '0; mem_addr = '0; mem_wdata = '0;
        if_req_b = 0; if_addr_b = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ce_n", {31'b0, sram_ce_n}, 32'd1);
        chk("rst_oe_n", {31'b0, sram_oe_n}, 32'd1);
        chk("rst_we_n", {31'b0, sram_we_n}, 32'd1);
        chk("rst_wdata_oe", {31'b0, sram_wdata_oe}, 32'd0);
        chk("rst_ready", {30'b0, if_ready, mem_ready}, 32'd0);
        chk("rst_stall", {31'b0, stall_req}, 32'd0);
        chk("rst_addr", {16'b0, sram_addr}, 32'd0);
        chk("rst_rdata", {if_rdata, mem_rdata}, 32'd0);
        chk("rst_stat", {16'b0, stat_if_stall_b}, 32'd0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_ce_n", {31'b0, sram_ce_n}, 32'd1);
        chk("idle_ready", {31'b0, if_ready}, 32'd0);

        // Directed table (WAIT_CYCLES = 1)
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, 16'h0000, 4, 0, 16'h6A05, 16'h0000, 2, 2, 0, 0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h8000, 16'hBEEF, 0, 4, 16'h0000, 16'h0000, 2, 0, 2, 3};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h8001, 16'h0000, 8, 4, 16'h6A11, 16'h6A00, 4, 4, 0, 0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h8000, 16'h0000, 0, 4, 16'h0000, 16'hBEEF, 2, 2, 0, 0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 16'h0020, 16'h0020, 16'h1234, 8, 4, 16'h1234, 16'h0000, 4, 2, 2, 3};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h0000, 4, 0, 16'h6AFE, 16'h0000, 2, 2, 0, 0};
        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].ir, vecs[i].mr, vecs[i].we, vecs[i].ia, vecs[i].ma, vecs[i].wd,
                    vecs[i].exp_ic, vecs[i].exp_mc, $sformatf("v%0d", i),
                    ic, mc, id, md, ce, oe, wen, drv);
            chk($sformatf("v%0d_if_cyc", i), ic, vecs[i].exp_ic);
            chk($sformatf("v%0d_mem_cyc", i), mc, vecs[i].exp_mc);
            if (vecs[i].ir) chk($sformatf("v%0d_if_rdata", i), {16'b0, id}, {16'b0, vecs[i].exp_id});
            if (vecs[i].mr && !vecs[i].we) chk($sformatf("v%0d_mem_rdata", i), {16'b0, md}, {16'b0, vecs[i].exp_md});
            chk($sformatf("v%0d_ce_cycles", i), ce, vecs[i].exp_ce);
            chk($sformatf("v%0d_oe_cycles", i), oe, vecs[i].exp_oe);
            chk($sformatf("v%0d_we_cycles", i), wen, vecs[i].exp_we);
            chk($sformatf("v%0d_drv_cycles", i), drv, vecs[i].exp_drv);
        end

        // Reset during the second ACCESS cycle of a fetch
        if_req = 1'b1; if_addr = 16'h0030;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_access", {31'b0, sram_ce_n}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_strobes", {29'b0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd7);
        chk("midrst_ready", {31'b0, if_ready}, 32'd0);
        rst = 1'b1;
        cyc = 1; ic = 0; id = '0;
        while (ic == 0 && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (if_ready) begin ic = cyc; id = if_rdata; end
        end
        if_req = 1'b0;
        @(negedge clk);
        chk("midrst_restart_cyc", ic, 4);
        chk("midrst_restart_rdata", {16'b0, id}, 32'h6A31);

        // Random traffic against the transaction-level model
        for (int a = 0; a < 256; a++) ref_mem[a] = init_word(16'(a));
        ref_mem[8'h00] = 16'hBEEF;
        ref_mem[8'h20] = 16'h1234;
        for (int t = 0; t < 80; t++) begin
            ir = 1'($urandom_range(0, 1));
            mr = 1'($urandom_range(0, 1));
            if (!ir && !mr) ir = 1'b1;
            we = 1'($urandom_range(0, 1));
            ia = 16'($urandom);
            ma = 16'($urandom);
            wd = 16'($urandom);
            e_md = '0;
            if (mr) begin
                if (we) ref_mem[ma[7:0]] = wd;
                else    e_md = ref_mem[ma[7:0]];
            end
            e_id = ref_mem[ia[7:0]];
            e_mc = mr ? (W + 3) : 0;
            e_ic = ir ? (mr ? 2 * (W + 3) : (W + 3)) : 0;
            run_txn(ir, mr, we, ia, ma, wd, e_ic, e_mc, $sformatf("r%0d", t),
                    ic, mc, id, md, ce, oe, wen, drv);
            chk($sformatf("r%0d_if_cyc", t), ic, e_ic);
            chk($sformatf("r%0d_mem_cyc", t), mc, e_mc);
            if (ir) chk($sformatf("r%0d_if_rdata", t), {16'b0, id}, {16'b0, e_id});
            if (mr && !we) chk($sformatf("r%0d_mem_rdata", t), {16'b0, md}, {16'b0, e_md});
            chk($sformatf("r%0d_ce_cycles", t), ce, (int'(ir) + int'(mr)) * (W + 1));
            chk($sformatf("r%0d_we_cycles", t), wen, (mr && we) ? (W + 1) : 0);
            chk($sformatf("r%0d_drv_cycles", t), drv, (mr && we) ? (W + 2) : 0);
        end

        // WAIT_CYCLES = 0: three back-to-back fetches with if_req held throughout
        fast_addr[0] = 16'h0040; fast_addr[1] = 16'h0041; fast_addr[2] = 16'h0042;
        if_req_b = 1'b1; if_addr_b = fast_addr[0];
        cyc = 1; nrdy = 0; fast_bad = 0;
        while (nrdy < 3 && cyc < 30) begin
            @(negedge clk);
            cyc++;
            if (mem_ready_b || !sram_we_n_b || sram_wdata_oe_b) fast_bad++;
            if (if_ready_b) begin
                fast_cyc[nrdy] = cyc;
                chk($sformatf("fast%0d_rdata", nrdy), {16'b0, if_rdata_b}, {16'b0, init_word(fast_addr[nrdy])});
                chk($sformatf("fast%0d_stall", nrdy), {31'b0, stall_req_b}, 32'd0);
                nrdy++;
                if (nrdy < 3) if_addr_b = fast_addr[nrdy];
                else          if_req_b = 1'b0;
            end
        end
        if_req_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("fast_count", nrdy, 3);
        if (nrdy == 3) begin
            chk("fast0_cyc", fast_cyc[0], 3);
            chk("fast1_cyc", fast_cyc[1], 6);
            chk("fast2_cyc", fast_cyc[2], 9);
        end
        chk("fast_no_write_activity", fast_bad, 0);
`ifdef SRAM_ARB_STAT_EN
        chk("fast_stat_if_stall", {16'b0, stat_if_stall_b}, 32'd6);
`else
        chk("fast_stat_if_stall", {16'b0, stat_if_stall_b}, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
